// File: rtl/raster_pkg.sv
// Shared types for the triangle rasterizer slice.
// Vertex bundle, edge coefficients and walk FSM states.
package raster_pkg;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;
  localparam int EW_DEF    = 36;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [7:0]         z;
    logic [31:0]        u;
    logic [31:0]        v;
  } vertex_t;

  typedef struct packed {
    logic signed [EW_DEF-1:0] a;
    logic signed [EW_DEF-1:0] b;
    logic signed [EW_DEF-1:0] c;
  } edge_coef_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    INIT,
    WALK,
    DONE
  } raster_state_t;

  function automatic logic signed [15:0] min3(
    input logic signed [15:0] a,
    input logic signed [15:0] b,
    input logic signed [15:0] c
  );
    logic signed [15:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic logic signed [15:0] max3(
    input logic signed [15:0] a,
    input logic signed [15:0] b,
    input logic signed [15:0] c
  );
    logic signed [15:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/raster_edge_setup.sv
// Edge i->j coefficients: A=yi-yj, B=xj-xi, C=xi*yj-xj*yi.
// Purely combinational; one instance per triangle edge.
module raster_edge_setup
  import raster_pkg::*;
(
  input  logic signed [15:0] xi_i,
  input  logic signed [15:0] yi_i,
  input  logic signed [15:0] xj_i,
  input  logic signed [15:0] yj_i,
  output edge_coef_t         coef_o
);

  logic signed [16:0] dy;
  logic signed [16:0] dx;
  logic signed [31:0] pij;
  logic signed [31:0] pji;

  assign dy  = 17'(yi_i) - 17'(yj_i);
  assign dx  = 17'(xj_i) - 17'(xi_i);
  assign pij = 32'(xi_i) * 32'(yj_i);
  assign pji = 32'(xj_i) * 32'(yi_i);

  assign coef_o.a = EW_DEF'(dy);
  assign coef_o.b = EW_DEF'(dx);
  assign coef_o.c = EW_DEF'(pij) - EW_DEF'(pji);

endmodule

// File: rtl/triangle_rasterizer.sv
// Bounding-box edge-function rasterizer, one fragment per cycle.
// Define RASTER_TOP_LEFT_EN for the top-left fill rule.
module triangle_rasterizer
  import raster_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int EW    = EW_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tri_valid,
  output logic        o_busy,
  input  logic [15:0] i_x0,
  input  logic [15:0] i_y0,
  input  logic [15:0] i_x1,
  input  logic [15:0] i_y1,
  input  logic [15:0] i_x2,
  input  logic [15:0] i_y2,
  input  logic [7:0]  i_z0,
  input  logic [7:0]  i_z1,
  input  logic [7:0]  i_z2,
  input  logic [31:0] i_u0,
  input  logic [31:0] i_v0,
  input  logic [31:0] i_u1,
  input  logic [31:0] i_v1,
  input  logic [31:0] i_u2,
  input  logic [31:0] i_v2,
  output logic        o_frag_valid,
  input  logic        i_frag_ready,
  output logic [15:0] o_frag_x,
  output logic [15:0] o_frag_y,
  output logic [7:0]  o_frag_z,
  output logic        o_tri_done
);

  localparam logic signed [16:0] XLIM = 17'(H_RES - 1);
  localparam logic signed [16:0] YLIM = 17'(V_RES - 1);

  raster_state_t      state_q;
  vertex_t            v_q [3];
  logic               busy_q;
  logic               fv_q;
  logic               done_q;
  logic [15:0]        fx_q;
  logic [15:0]        fy_q;
  logic [7:0]         fz_q;
  logic [15:0]        x_q;
  logic [15:0]        y_q;
  logic [15:0]        xmin_q;
  logic [15:0]        xmax_q;
  logic [15:0]        ymin_q;
  logic [15:0]        ymax_q;
  logic signed [EW-1:0] a_q [3];
  logic signed [EW-1:0] b_q [3];
  logic signed [EW-1:0] c_q [3];
  logic signed [EW-1:0] e_q [3];
  logic signed [EW-1:0] r_q [3];

  logic signed [15:0]   vx [3];
  logic signed [15:0]   vy [3];
  edge_coef_t           coef [3];
  logic signed [EW-1:0] ra [3];
  logic signed [EW-1:0] rb [3];
  logic signed [EW-1:0] rc [3];
  logic signed [EW-1:0] e_init [3];
  logic signed [EW-1:0] area;
  logic signed [EW-1:0] xs;
  logic signed [EW-1:0] ys;
  logic signed [15:0]   xlo, xhi, ylo, yhi;
  logic signed [16:0]   bx0, bx1, by0, by1;
  logic                 neg;
  logic                 empty;
  logic                 slot_free;
  logic [2:0]           ins;
  logic                 unused_ok;

  for (genvar i = 0; i < 3; i++) begin : g_edge
    assign vx[i] = v_q[i].x;
    assign vy[i] = v_q[i].y;
    raster_edge_setup u_edge (
      .xi_i  (vx[i]),
      .yi_i  (vy[i]),
      .xj_i  (vx[(i+1)%3]),
      .yj_i  (vy[(i+1)%3]),
      .coef_o(coef[i])
    );
    assign ra[i] = EW'(coef[i].a);
    assign rb[i] = EW'(coef[i].b);
    assign rc[i] = EW'(coef[i].c);
    assign e_init[i] = a_q[i] * xs + b_q[i] * ys + c_q[i];
  end

  assign area = ra[0] * EW'(vx[2]) + rb[0] * EW'(vy[2]) + rc[0];
  assign neg  = area[EW-1];

  assign xlo = min3(vx[0], vx[1], vx[2]);
  assign xhi = max3(vx[0], vx[1], vx[2]);
  assign ylo = min3(vy[0], vy[1], vy[2]);
  assign yhi = max3(vy[0], vy[1], vy[2]);
  assign bx0 = xlo[15] ? 17'sd0 : 17'(xlo);
  assign bx1 = (17'(xhi) > XLIM) ? XLIM : 17'(xhi);
  assign by0 = ylo[15] ? 17'sd0 : 17'(ylo);
  assign by1 = (17'(yhi) > YLIM) ? YLIM : 17'(yhi);
  assign empty = (bx0 > bx1) || (by0 > by1);

  assign xs = EW'(xmin_q);
  assign ys = EW'(ymin_q);
  assign slot_free = !fv_q || i_frag_ready;

  always_comb begin
    ins = '0;
    for (int i = 0; i < 3; i++) begin
`ifdef RASTER_TOP_LEFT_EN
      ins[i] = (e_q[i] > 0) ||
               ((e_q[i] == 0) &&
                ((a_q[i] > 0) || ((a_q[i] == 0) && (b_q[i] < 0))));
`else
      ins[i] = !e_q[i][EW-1];
`endif
    end
  end

  assign unused_ok = ^{v_q[0].u, v_q[0].v, v_q[1].z, v_q[1].u,
                       v_q[1].v, v_q[2].z, v_q[2].u, v_q[2].v};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      fz_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        v_q[i] <= '0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
        e_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (fv_q && i_frag_ready) fv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_tri_valid) begin
            v_q[0]  <= '{x: i_x0, y: i_y0, z: i_z0, u: i_u0, v: i_v0};
            v_q[1]  <= '{x: i_x1, y: i_y1, z: i_z1, u: i_u1, v: i_v1};
            v_q[2]  <= '{x: i_x2, y: i_y2, z: i_z2, u: i_u2, v: i_v2};
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          // Normalize so the interior is always the non-negative side.
          for (int i = 0; i < 3; i++) begin
            a_q[i] <= neg ? -ra[i] : ra[i];
            b_q[i] <= neg ? -rb[i] : rb[i];
            c_q[i] <= neg ? -rc[i] : rc[i];
          end
          xmin_q  <= bx0[15:0];
          xmax_q  <= bx1[15:0];
          ymin_q  <= by0[15:0];
          ymax_q  <= by1[15:0];
          state_q <= ((area == 0) || empty) ? DONE : INIT;
        end
        INIT: begin
          for (int i = 0; i < 3; i++) begin
            e_q[i] <= e_init[i];
            r_q[i] <= e_init[i];
          end
          x_q     <= xmin_q;
          y_q     <= ymin_q;
          state_q <= WALK;
        end
        WALK: begin
          if (slot_free) begin
            if (&ins) begin
              fv_q <= 1'b1;
              fx_q <= x_q;
              fy_q <= y_q;
              fz_q <= v_q[0].z;
            end
            if (x_q == xmax_q) begin
              if (y_q == ymax_q) begin
                state_q <= DONE;
              end else begin
                x_q <= xmin_q;
                y_q <= y_q + 16'd1;
                for (int i = 0; i < 3; i++) begin
                  r_q[i] <= r_q[i] + b_q[i];
                  e_q[i] <= r_q[i] + b_q[i];
                end
              end
            end else begin
              x_q <= x_q + 16'd1;
              for (int i = 0; i < 3; i++) e_q[i] <= e_q[i] + a_q[i];
            end
          end
        end
        DONE: begin
          if (slot_free) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_frag_valid = fv_q;
  assign o_frag_x     = fx_q;
  assign o_frag_y     = fy_q;
  assign o_frag_z     = fz_q;
  assign o_tri_done   = done_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Randomized scoreboard bench for triangle_rasterizer.
// Reference model evaluates edge functions directly per pixel.
module tb_triangle_rasterizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tri_valid;
  logic        busy;
  logic [15:0] x0, y0, x1, y1, x2, y2;
  logic [7:0]  z0, z1, z2;
  logic [31:0] u0, v0, u1, v1, u2, v2;
  logic        fv;
  logic        frag_ready;
  logic [15:0] fx, fy;
  logic [7:0]  fz;
  logic        done;

  int checks = 0;
  int errors = 0;

  int gx[$], gy[$], ex[$], ey[$];
  logic [7:0] gz[$];
  int ndone, done_at, stall_err, stall_cnt;
  bit tmo, busy_at_done;

  always #5 clk = ~clk;

  triangle_rasterizer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tri_valid (tri_valid),
    .o_busy      (busy),
    .i_x0        (x0),
    .i_y0        (y0),
    .i_x1        (x1),
    .i_y1        (y1),
    .i_x2        (x2),
    .i_y2        (y2),
    .i_z0        (z0),
    .i_z1        (z1),
    .i_z2        (z2),
    .i_u0        (u0),
    .i_v0        (v0),
    .i_u1        (u1),
    .i_v1        (v1),
    .i_u2        (u2),
    .i_v2        (v2),
    .o_frag_valid(fv),
    .i_frag_ready(frag_ready),
    .o_frag_x    (fx),
    .o_frag_y    (fy),
    .o_frag_z    (fz),
    .o_tri_done  (done)
  );

  // Expected fragments in raster (row-major) order.
  function automatic void model(input int vx[3], input int vy[3]);
    longint a[3], b[3], c[3], area, e;
    int xl, xh, yl, yh;
    bit ok;
    ex.delete();
    ey.delete();
    for (int i = 0; i < 3; i++) begin
      int j;
      j = (i + 1) % 3;
      a[i] = vy[i] - vy[j];
      b[i] = vx[j] - vx[i];
      c[i] = longint'(vx[i]) * vy[j] - longint'(vx[j]) * vy[i];
    end
    area = a[0] * vx[2] + b[0] * vy[2] + c[0];
    if (area == 0) return;
    if (area < 0)
      for (int i = 0; i < 3; i++) begin
        a[i] = -a[i];
        b[i] = -b[i];
        c[i] = -c[i];
      end
    xl = vx[0]; xh = vx[0]; yl = vy[0]; yh = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < xl) xl = vx[i];
      if (vx[i] > xh) xh = vx[i];
      if (vy[i] < yl) yl = vy[i];
      if (vy[i] > yh) yh = vy[i];
    end
    if (xl < 0) xl = 0;
    if (yl < 0) yl = 0;
    if (xh > 319) xh = 319;
    if (yh > 239) yh = 239;
    for (int py = yl; py <= yh; py++)
      for (int px = xl; px <= xh; px++) begin
        ok = 1;
        for (int i = 0; i < 3; i++) begin
          e = a[i] * px + b[i] * py + c[i];
`ifdef RASTER_TOP_LEFT_EN
          if (!(e > 0 || (e == 0 &&
                (a[i] > 0 || (a[i] == 0 && b[i] < 0))))) ok = 0;
`else
          if (e < 0) ok = 0;
`endif
        end
        if (ok) begin
          ex.push_back(px);
          ey.push_back(py);
        end
      end
  endfunction

  // mode 0: always ready, 1: random ready + junk triangles while busy,
  // 2: ready low for cycles 12..16. abort_at>0 leaves mid-walk.
  task automatic run_tri(input int vx[3], input int vy[3],
                         input logic [7:0] zz, input int mode,
                         input int abort_at);
    bit pst, rdy;
    logic [15:0] px, py;
    logic [7:0] pz;
    gx.delete(); gy.delete(); gz.delete();
    ndone = 0; done_at = 0; tmo = 0;
    stall_err = 0; stall_cnt = 0; busy_at_done = 1;
    px = '0; py = '0; pz = '0;
    @(negedge clk);
    for (int w = 0; w < 50 && busy; w++) @(negedge clk);
    x0 = 16'(vx[0]); y0 = 16'(vy[0]);
    x1 = 16'(vx[1]); y1 = 16'(vy[1]);
    x2 = 16'(vx[2]); y2 = 16'(vy[2]);
    z0 = zz; z1 = 8'($urandom); z2 = 8'($urandom);
    u0 = $urandom; v0 = $urandom; u1 = $urandom;
    v1 = $urandom; u2 = $urandom; v2 = $urandom;
    tri_valid = 1; frag_ready = 1;
    @(negedge clk);
    tri_valid = 0;
    pst = 0;
    for (int k = 1; k <= 20000; k++) begin
      if (abort_at != 0 && k == abort_at) return;
      rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) :
            (mode == 2) ? !(k >= 12 && k < 17) : 1'b1;
      frag_ready = rdy;
      if (pst) begin
        stall_cnt++;
        if (!fv || fx !== px || fy !== py || fz !== pz) stall_err++;
      end
      if (fv && rdy) begin
        gx.push_back(int'(fx));
        gy.push_back(int'(fy));
        gz.push_back(fz);
      end
      pst = fv && !rdy;
      px = fx; py = fy; pz = fz;
      if (done) begin
        ndone++;
        done_at = k;
        busy_at_done = busy;
        tri_valid = 0;
        frag_ready = 1;
        repeat (3) begin
          @(negedge clk);
          if (done) ndone++;
          if (fv) stall_err++;
        end
        return;
      end
      if (mode == 1) begin
        tri_valid = 1'($urandom_range(0, 1));
        x0 = 16'($urandom); y1 = 16'($urandom); z0 = 8'($urandom);
      end
      @(negedge clk);
    end
    tmo = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tri_valid = 0; frag_ready = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || fv !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b valid=%b done=%b want 000",
               busy, fv, done);
    end
    checks++;
    if (fx !== 0 || fy !== 0 || fz !== 0) begin
      errors++;
      $display("FAIL reset_data x=%0d y=%0d z=%0d want 0", fx, fy, fz);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 0 || fv !== 0) begin
      errors++;
      $display("FAIL reset_idle busy=%b valid=%b want 00", busy, fv);
    end
  endtask

  task automatic test_basic(input string nm, input int vx[3],
                            input int vy[3]);
    int bad;
    model(vx, vy);
    run_tri(vx, vy, 8'h5a, 0, 0);
    checks++;
    if (tmo || ndone !== 1 || busy_at_done !== 0) begin
      errors++;
      $display("FAIL %s_done tmo=%0d pulses=%0d busy=%b want 0/1/0",
               nm, tmo, ndone, busy_at_done);
    end
    checks++;
    if (gx.size() !== 66) begin
      errors++;
      $display("FAIL %s_count got %0d want 66", nm, gx.size());
    end
    bad = 0;
    foreach (gx[i])
      if (gx[i] < 10 || gy[i] < 10 || gx[i] + gy[i] > 30 ||
          gz[i] !== 8'h5a) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_region got %0d bad fragments want 0", nm, bad);
    end
    checks++;
    if (gx.size() !== ex.size()) begin
      errors++;
      $display("FAIL %s_model_count got %0d want %0d",
               nm, gx.size(), ex.size());
    end else begin
      foreach (gx[i]) begin
        checks++;
        if (gx[i] !== ex[i] || gy[i] !== ey[i]) begin
          errors++;
          $display("FAIL %s_frag[%0d] got (%0d,%0d) want (%0d,%0d)",
                   nm, i, gx[i], gy[i], ex[i], ey[i]);
        end
      end
    end
  endtask

  task automatic test_square();
    int cnt[int], mcnt[int];
    int dup, mdup;
    model('{10, 20, 20}, '{10, 10, 20});
    foreach (ex[i]) mcnt[ex[i] * 1024 + ey[i]]++;
    run_tri('{10, 20, 20}, '{10, 10, 20}, 8'h11, 1, 0);
    foreach (gx[i]) cnt[gx[i] * 1024 + gy[i]]++;
    model('{10, 20, 10}, '{10, 20, 20});
    foreach (ex[i]) mcnt[ex[i] * 1024 + ey[i]]++;
    run_tri('{10, 20, 10}, '{10, 20, 20}, 8'h22, 1, 0);
    foreach (gx[i]) cnt[gx[i] * 1024 + gy[i]]++;
    dup = 0; mdup = 0;
    foreach (cnt[k]) if (cnt[k] > 1) dup++;
    foreach (mcnt[k]) if (mcnt[k] > 1) mdup++;
    checks++;
    if (cnt.num() !== mcnt.num()) begin
      errors++;
      $display("FAIL square_unique got %0d want %0d",
               cnt.num(), mcnt.num());
    end
    checks++;
    if (dup !== mdup) begin
      errors++;
      $display("FAIL square_dups got %0d want %0d", dup, mdup);
    end
`ifndef RASTER_TOP_LEFT_EN
    checks++;
    if (cnt.num() !== 121 || dup !== 11) begin
      errors++;
      $display("FAIL square_incl got %0d/%0d want 121/11",
               cnt.num(), dup);
    end
`else
    checks++;
    if (dup !== 0) begin
      errors++;
      $display("FAIL square_tl_dups got %0d want 0", dup);
    end
`endif
  endtask

  task automatic test_empty(input string nm, input int vx[3],
                            input int vy[3]);
    run_tri(vx, vy, 8'h33, 0, 0);
    checks++;
    if (tmo || gx.size() !== 0 || ndone !== 1) begin
      errors++;
      $display("FAIL %s frags=%0d pulses=%0d tmo=%0d want 0/1/0",
               nm, gx.size(), ndone, tmo);
    end
    checks++;
    if (done_at > 4 || busy_at_done !== 0) begin
      errors++;
      $display("FAIL %s_latency done_at=%0d busy=%b want <=4/0",
               nm, done_at, busy_at_done);
    end
  endtask

  task automatic test_stall_reset();
    run_tri('{10, 20, 10}, '{10, 10, 20}, 8'h5a, 2, 0);
    checks++;
    if (gx.size() !== 66 || ndone !== 1) begin
      errors++;
      $display("FAIL stall_count got %0d/%0d want 66/1",
               gx.size(), ndone);
    end
    checks++;
    if (stall_cnt < 5 || stall_err !== 0) begin
      errors++;
      $display("FAIL stall_hold stalls=%0d changes=%0d want >=5/0",
               stall_cnt, stall_err);
    end
    run_tri('{10, 20, 10}, '{10, 10, 20}, 8'h5a, 0, 10);
    rst_n = 0;
    #1;
    checks++;
    if (fv !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL midreset valid=%b busy=%b done=%b want 000",
               fv, busy, done);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (fv !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL post_reset valid=%b busy=%b want 00", fv, busy);
    end
    test_basic("after_reset", '{10, 20, 10}, '{10, 10, 20});
  endtask

  task automatic test_random();
    int vx[3], vy[3];
    int cx, cy;
    logic [7:0] zz;
    for (int t = 0; t < 16; t++) begin
      cx = int'($urandom_range(0, 380)) - 30;
      cy = int'($urandom_range(0, 300)) - 30;
      for (int i = 0; i < 3; i++) begin
        vx[i] = cx + int'($urandom_range(0, 40)) - 20;
        vy[i] = cy + int'($urandom_range(0, 40)) - 20;
      end
      zz = 8'($urandom);
      model(vx, vy);
      run_tri(vx, vy, zz, 1, 0);
      checks++;
      if (tmo || ndone !== 1 || stall_err !== 0) begin
        errors++;
        $display("FAIL rand%0d_ctrl tmo=%0d pulses=%0d hold=%0d",
                 t, tmo, ndone, stall_err);
      end
      checks++;
      if (gx.size() !== ex.size()) begin
        errors++;
        $display("FAIL rand%0d_count got %0d want %0d",
                 t, gx.size(), ex.size());
      end else begin
        foreach (gx[i]) begin
          checks++;
          if (gx[i] !== ex[i] || gy[i] !== ey[i] || gz[i] !== zz) begin
            errors++;
            $display("FAIL rand%0d_frag[%0d] got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     t, i, gx[i], gy[i], gz[i], ex[i], ey[i], zz);
          end
        end
      end
    end
  endtask

  initial begin
    tri_valid = 0; frag_ready = 1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    z0 = '0; z1 = '0; z2 = '0;
    u0 = '0; v0 = '0; u1 = '0; v1 = '0; u2 = '0; v2 = '0;
    test_reset();
    test_basic("basic", '{10, 20, 10}, '{10, 10, 20});
    test_basic("reversed", '{10, 20, 10}, '{20, 10, 10});
    test_square();
    test_empty("offscreen", '{-50, -40, -50}, '{-50, -50, -40});
    test_empty("collinear", '{0, 5, 10}, '{0, 5, 10});
    test_stall_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/triangle_rasterizer.md
Name: triangle_rasterizer

Overview:
- Consumer end of the triangle handshake: accepts one assembled triangle at a time from the triangle assembler via i_tri_valid / o_busy.
- Walks the triangle's screen-clamped bounding box with incremental edge functions and emits one covered-pixel fragment per cycle to the fragment stage.
- Sits between the triangle assembler and the depth/texture stage.

Parameters:
- H_RES, 320, screen width in pixels.
- V_RES, 240, screen height in pixels.
- EW, 36, signed width of edge-function accumulators.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_tri_valid  in  1  triangle presented on vertex inputs.
- o_busy  out  1  high while a triangle is being processed; a new triangle is accepted only when low.
- i_x0,i_y0,i_x1,i_y1,i_x2,i_y2  in  16 each  signed integer screen coordinates.
- i_z0,i_z1,i_z2  in  8 each  vertex depth.
- i_u0,i_v0,i_u1,i_v1,i_u2,i_v2  in  32 each  texture coordinates; latched and ignored in this revision.
- o_frag_valid  out  1  fragment present.
- i_frag_ready  in  1  downstream accepts the fragment.
- o_frag_x  out  16  pixel x, 0..H_RES-1.
- o_frag_y  out  16  pixel y, 0..V_RES-1.
- o_frag_z  out  8  flat depth, equal to the latched z0.
- o_tri_done  out  1  one-cycle pulse when the walk for the current triangle ends.

Behaviour:
- Reset (async on i_rst_n low): state IDLE; o_busy, o_frag_valid and o_tri_done are 0; o_frag_x/y/z are 0. Reset mid-walk discards the triangle.
- Accept: i_tri_valid && !o_busy at a rising edge latches all vertices. o_busy goes high the next cycle. i_tri_valid while busy is ignored.
- States:
  - IDLE -> SETUP on accept.
  - SETUP (1 cycle): per edge i->j, compute A=yi-yj, B=xj-xi, C=xi*yj-xj*yi. Area = E01(v2). If area<0, negate all A,B,C. Compute bbox = min/max of vertices, clamped to [0,H_RES-1] x [0,V_RES-1].
  - SETUP -> DONE if area==0 or the clamped bbox is empty (min>max on either axis). Otherwise SETUP -> INIT.
  - INIT (1 cycle): evaluate E0,E1,E2 at (xmin,ymin) into the current and row-start registers.
  - WALK: one pixel per cycle while the output slot is free (!o_frag_valid || i_frag_ready).
    - Inside test per Optional Feature; an inside pixel loads the output registers with o_frag_valid=1.
    - Step x+1 adds A. At xmax, step y+1 adds B to the row-start registers and reloads them.
    - After evaluating (xmax,ymax) -> DONE.
  - DONE: waits until the output slot drains, pulses o_tri_done for 1 cycle, then -> IDLE. o_busy drops in the same cycle as the o_tri_done pulse.
- Latency: first fragment can be valid 3 cycles after the accept edge.
- Backpressure: while o_frag_valid && !i_frag_ready, the walk stalls and o_frag_x/y/z are held stable. No fragment is lost or duplicated.
- Windings: both windings rasterize identically; culling is upstream.
- Arithmetic: coordinate differences are 17-bit signed and products are sign-extended to EW. No overflow is possible for 16-bit inputs.

Optional Feature:
- Macro RASTER_TOP_LEFT_EN.
- Defined: a pixel is inside if each Ei>0, or Ei==0 and edge i is top-left, i.e. (A>0) || (A==0 && B<0), evaluated on the normalized coefficients. Shared edges are emitted by exactly one triangle.
- Undefined: inside if all Ei>=0 (inclusive; shared-edge pixels are emitted twice).

Decomposition:
- Shared raster_pkg contains:
  - H_RES/V_RES defaults.
  - vertex struct (x, y, z, u, v).
  - edge_coef_t struct {A, B, C} with EW-bit fields.
  - raster_state_t enum {IDLE, SETUP, INIT, WALK, DONE}.
- One natural sub-module, raster_edge_setup: combinational A/B/C for one edge, instantiated three times.

Test Plan:
- Triangle (10,10),(20,10),(10,20), macro off -> exactly 66 fragments, all with x>=10, y>=10, x+y<=30; o_frag_z=z0; one o_tri_done pulse.
- Same vertices in reversed order -> identical set of 66 fragments.
- Square (10,10)-(20,20) split into two triangles along its diagonal, macro on -> 121 unique fragments in total, none duplicated.
- Off-screen triangle (-50,-50),(-40,-50),(-50,-40) -> zero fragments; o_tri_done pulses; o_busy low within 4 cycles of accept.
- Collinear vertices (0,0),(5,5),(10,10) -> zero fragments, one o_tri_done pulse.
- First test with i_frag_ready held low for 5 cycles mid-walk, then i_rst_n pulsed mid-walk -> during the stall x/y are held stable and the count is still 66. After reset, o_frag_valid and o_busy are 0 and the next triangle rasterizes normally.
